// File: rtl/iq_tone_rom_if.sv
`default_nettype none
// ============================================================================
//  Module      : iq_tone_rom_if
//  Description : Read-port bundle for the quadrature tone ROM: enable,
//                address, registered sample and its valid flag.
//  Revision    : 1.0
// ============================================================================
interface iq_tone_rom_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          ena;
    logic [AW-1:0] addra;
    logic [DW-1:0] douta;
    logic          rd_valid;

    // Requester side: issues reads, receives samples
    modport master (
        output ena,
        output addra,
        input  douta,
        input  rd_valid
    );

    // ROM side: accepts reads, returns samples
    modport slave (
        input  ena,
        input  addra,
        output douta,
        output rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/iq_tone_rom.sv
`default_nettype none
// ============================================================================
//  Module      : iq_tone_rom
//  Description : Synchronous single-port cosine/sine tone ROM for the DDS path.
//                Contents are generated at elaboration from CHANNEL, DEPTH,
//                CYCLES and AMP; addresses at or beyond DEPTH read zero.
//                One-cycle read latency with a registered output.
//  Revision    : 1.0
// ============================================================================
module iq_tone_rom #(
    parameter int CHANNEL = 0,
    parameter int DEPTH   = 241,
    parameter int CYCLES  = 1,
    parameter int AMP     = 32000,
    parameter int AW      = 8,
    parameter int DW      = 16
) (
    input  wire logic     GCLK,
    input  wire logic     reset,
    iq_tone_rom_if.slave  bus
);

    localparam int  ROM_SIZE = 1 << AW;
    localparam int  SAT_MAX  = (1 << (DW - 1)) - 1;
    localparam real PI       = 3.14159265358979323846;

    // The table must fit the address space, and the bundle widths must match
    if (DEPTH > ROM_SIZE) begin : g_depth_check
        $error("iq_tone_rom: DEPTH (%0d) exceeds 2**AW (%0d)", DEPTH, ROM_SIZE);
    end
    if (($bits(bus.addra) != AW) || ($bits(bus.douta) != DW)) begin : g_width_check
        $error("iq_tone_rom: interface widths do not match AW/DW");
    end

    // One table entry: round half away from zero, then saturate symmetrically
    function automatic logic signed [DW-1:0] tone_sample(input int n);
        real ph;
        real x;
        real r;
        int  v;
        if (n >= DEPTH) begin
            return '0;
        end
        ph = 2.0 * PI * real'(CYCLES) * real'(n) / real'(DEPTH);
        x  = real'(AMP) * ((CHANNEL == 0) ? $cos(ph) : $sin(ph));
        r  = (x >= 0.0) ? (x + 0.5) : (x - 0.5);
        v  = $rtoi(r);
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < -SAT_MAX) begin
            v = -SAT_MAX;
        end
        return DW'(v);
    endfunction

    // Constant table covering the full address space
    logic signed [DW-1:0] rom [ROM_SIZE];

    for (genvar i = 0; i < ROM_SIZE; i++) begin : g_rom
        localparam logic signed [DW-1:0] ENTRY = tone_sample(i);
        assign rom[i] = ENTRY;
    end

    // Output register powers up cleared so no X ever reaches the DAC path
    logic [DW-1:0] sample_q = '0;
    logic          valid_q  = 1'b0;

    // Registered read: reset clears, ena loads a new sample, otherwise hold
    always_ff @(posedge GCLK) begin
        if (reset) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else if (bus.ena) begin
            sample_q <= rom[bus.addra];
            valid_q  <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.douta    = sample_q;
    assign bus.rd_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_tone_rom.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_tone_rom
//  Description : Self-checking bench driving an I and a Q tone ROM in
//                lock-step; expected samples queue up as stimulus is applied
//                and are compared one cycle later.
//  Revision    : 1.0
// ============================================================================
module tb_iq_tone_rom;

    localparam int  DEPTH = 241;
    localparam int  AMP   = 32000;
    localparam real PI    = 3.14159265358979323846;

    logic       GCLK  = 1'b0;
    logic       reset = 1'b0;
    logic       ena   = 1'b0;
    logic [7:0] addra = 8'd0;

    iq_tone_rom_if #(.AW(8), .DW(16)) bus_i ();
    iq_tone_rom_if #(.AW(8), .DW(16)) bus_q ();

    assign bus_i.ena   = ena;
    assign bus_i.addra = addra;
    assign bus_q.ena   = ena;
    assign bus_q.addra = addra;

    iq_tone_rom #(.CHANNEL(0), .DEPTH(DEPTH), .CYCLES(1), .AMP(AMP), .AW(8), .DW(16)) dut_i (
        .GCLK  (GCLK),
        .reset (reset),
        .bus   (bus_i.slave)
    );

    iq_tone_rom #(.CHANNEL(1), .DEPTH(DEPTH), .CYCLES(1), .AMP(AMP), .AW(8), .DW(16)) dut_q (
        .GCLK  (GCLK),
        .reset (reset),
        .bus   (bus_q.slave)
    );

    always #5 GCLK = ~GCLK;

    typedef struct {
        string name;
        int    ei;
        int    eq;
        int    ev;
        int    tag;
    } exp_t;

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] a;
        int         ei;
        int         eq;
        int         ev;
        string      name;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_i = 0;
    int   model_q = 0;
    int   cap_i [DEPTH];
    int   cap_q [DEPTH];

    // Reference sample: round(AMP*cos/sin(2*pi*n/DEPTH)), half away from zero
    function automatic int tone(input int ch, input int n);
        real ph;
        real x;
        int  v;
        if (n >= DEPTH) return 0;
        ph = 2.0 * PI * real'(n) / real'(DEPTH);
        x  = real'(AMP) * ((ch == 0) ? $cos(ph) : $sin(ph));
        v  = $rtoi((x >= 0.0) ? (x + 0.5) : (x - 0.5));
        if (v > 32767)  v = 32767;
        if (v < -32767) v = -32767;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint val, input longint lo, input longint hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected range [%0d,%0d]", name, val, lo, hi);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge
    task automatic drive_exp(input logic r, input logic e, input logic [7:0] a,
                             input int ei, input int eq, input int ev,
                             input string name, input int tag);
        exp_t x;
        @(negedge GCLK);
        reset = r;
        ena   = e;
        addra = a;
        x.name = name; x.ei = ei; x.eq = eq; x.ev = ev; x.tag = tag;
        sb.push_back(x);
        model_i = ei;
        model_q = eq;
    endtask

    // Same, with expectations derived from the register behaviour
    task automatic apply(input logic r, input logic e, input logic [7:0] a,
                         input string name, input int tag);
        if (r)      drive_exp(r, e, a, 0, 0, 0, name, tag);
        else if (e) drive_exp(r, e, a, tone(0, int'(a)), tone(1, int'(a)), 1, name, tag);
        else        drive_exp(r, e, a, model_i, model_q, 0, name, tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) begin
            if (sb.size() == 0) break;
            @(posedge GCLK);
            #2;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Compare queued expectations against the outputs just after each edge
    always @(posedge GCLK) begin
        exp_t x;
        #1;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check({x.name, "_i"},     $signed(bus_i.douta), x.ei);
            check({x.name, "_q"},     $signed(bus_q.douta), x.eq);
            check({x.name, "_valid"}, {31'd0, bus_i.rd_valid}, x.ev);
            check({x.name, "_validq"}, {31'd0, bus_q.rd_valid}, x.ev);
            if (x.tag >= 0 && x.tag < DEPTH) begin
                cap_i[x.tag] = int'($signed(bus_i.douta));
                cap_q[x.tag] = int'($signed(bus_q.douta));
            end
        end
    end

    initial begin
        vec_t vecs [7];
        longint pwr;

        vecs[0] = '{1'b1, 1'b1, 8'd0,   0,     0, 0, "rst0"};
        vecs[1] = '{1'b1, 1'b1, 8'd0,   0,     0, 0, "rst1"};
        vecs[2] = '{1'b1, 1'b1, 8'd0,   0,     0, 0, "rst2"};
        vecs[3] = '{1'b0, 1'b1, 8'd0,   32000, 0, 1, "first_read"};
        vecs[4] = '{1'b0, 1'b1, 8'd241, 0,     0, 1, "oor241"};
        vecs[5] = '{1'b0, 1'b1, 8'd250, 0,     0, 1, "oor250"};
        vecs[6] = '{1'b0, 1'b1, 8'd255, 0,     0, 1, "oor255"};

        // Power-up state before any clock edge
        #1;
        check("powerup_i",     $signed(bus_i.douta), 0);
        check("powerup_q",     $signed(bus_q.douta), 0);
        check("powerup_valid", {31'd0, bus_i.rd_valid}, 0);

        // Reset, first read, and out-of-range addresses
        for (int k = 0; k < 7; k++) begin
            drive_exp(vecs[k].r, vecs[k].e, vecs[k].a, vecs[k].ei, vecs[k].eq,
                      vecs[k].ev, vecs[k].name, -1);
        end
        drain();

        // Back-to-back sweep over every table entry
        for (int k = 0; k < DEPTH; k++) begin
            apply(1'b0, 1'b1, 8'(k), "sweep", k);
        end
        drain();

        // Table shape on the captured samples
        for (int n = 1; n < DEPTH; n++) begin
            check("sym_i", cap_i[n], cap_i[DEPTH - n]);
            check("sym_q", cap_q[n], -cap_q[DEPTH - n]);
        end
        for (int n = 0; n < DEPTH; n++) begin
            check_range("mag_i", longint'(cap_i[n]), -AMP, AMP);
            check_range("mag_q", longint'(cap_q[n]), -AMP, AMP);
            pwr = longint'(cap_i[n]) * cap_i[n] + longint'(cap_q[n]) * cap_q[n];
            check_range("circle", pwr, longint'(AMP) * AMP - 2 * AMP,
                        longint'(AMP) * AMP + 2 * AMP);
        end

        // Enable gating: hold T[10] while ena is low and the address moves
        apply(1'b0, 1'b1, 8'd10, "en_load", -1);
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b0, 8'(20 + k * 7), "en_hold", -1);
        end
        apply(1'b0, 1'b1, 8'd50, "en_resume", -1);
        apply(1'b0, 1'b1, 8'd51, "en_next", -1);
        drain();

        // Mid-stream reset for one cycle at address 120
        for (int k = 110; k <= 130; k++) begin
            apply((k == 120) ? 1'b1 : 1'b0, 1'b1, 8'(k), (k == 120) ? "mid_rst" : "mid_sweep", -1);
        end
        drain();

        // Seamless wrap from the last entry back to zero
        apply(1'b0, 1'b1, 8'd239, "wrap239", -1);
        apply(1'b0, 1'b1, 8'd240, "wrap240", -1);
        apply(1'b0, 1'b1, 8'd0,   "wrap0",   -1);
        apply(1'b0, 1'b1, 8'd1,   "wrap1",   -1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
